// File: rtl/enc10_rr_if.sv
// Request/grant bus for the 10-line request encoder: request lines and ack in,
// presented channel code, valid and any-pending out.
interface enc10_rr_if;
  logic [9:0] a;
  logic       ack;
  logic [3:0] q;
  logic       vld;
  logic       any;

  modport master (output a, ack, input q, vld, any);
  modport slave  (input a, ack, output q, vld, any);
endinterface

// File: rtl/enc10_rr.sv
// Registered 10-line request encoder: captures request events into a pending set
// and presents one channel code at a time with a valid/ack handshake.
module enc10_rr #(
  parameter bit EDGE = 1'b1,
  parameter bit MODE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  enc10_rr_if.slave    bus
);

  logic [9:0] r_s;
  logic [9:0] r_p;
  logic [3:0] r_c;
  logic       r_vld;
  logic [3:0] r_r;

  logic [9:0] w_evt;
  logic [9:0] w_clr;
  logic [9:0] w_mask;
  logic [3:0] w_base;
  logic [4:0] w_idx;
  logic [3:0] w_win;
  logic       w_found;
  logic       w_serve;

  assign w_serve = bus.ack & r_vld;
  assign w_evt   = EDGE ? (bus.a & ~r_s) : bus.a;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_clr
      assign w_clr[gi] = w_serve & (r_c == 4'(gi));
    end
  endgenerate

  // The channel being served this cycle is excluded so a fresh grant can follow at once.
  assign w_mask = r_p & ~w_clr;
  assign w_base = MODE ? r_r : 4'd0;

  always_comb begin
    w_found = 1'b0;
    w_win   = 4'd0;
    w_idx   = 5'd0;
    for (int k = 0; k < 10; k++) begin
      w_idx = {1'b0, w_base} + 5'(k);
      if (w_idx >= 5'd10) begin
        w_idx = w_idx - 5'd10;
      end
      if (!w_found && w_mask[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[3:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s   <= '0;
      r_p   <= '0;
      r_c   <= '0;
      r_vld <= 1'b0;
      r_r   <= '0;
    end else begin
      r_s <= bus.a;
      // A new event on the served channel outranks its clear.
      r_p <= w_evt | (r_p & ~w_clr);
      if (!r_vld || bus.ack) begin
        if (w_found) begin
          r_c   <= w_win;
          r_vld <= 1'b1;
        end else begin
          r_vld <= 1'b0;
        end
      end
      if (w_serve) begin
        r_r <= (r_c == 4'd9) ? 4'd0 : r_c + 4'd1;
      end
    end
  end

  assign bus.q   = r_c;
  assign bus.vld = r_vld;
  assign bus.any = |r_p;

endmodule

// File: tb/tb_enc10_rr.sv
// Self-checking bench for enc10_rr: two instances (edge/fixed and level/round-robin)
// checked against directed expectations and a behavioural model.
module tb_enc10_rr;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  enc10_rr_if bus0 ();
  enc10_rr_if bus1 ();

  enc10_rr #(.EDGE(1'b1), .MODE(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  enc10_rr #(.EDGE(1'b0), .MODE(1'b1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending set, presented channel, pointer, per instance.
  bit [9:0] m_s [2];
  bit [9:0] m_p [2];
  int       m_c [2];
  bit       m_v [2];
  int       m_r [2];
  localparam bit EDGE_OF [2] = '{1'b1, 1'b0};
  localparam bit MODE_OF [2] = '{1'b0, 1'b1};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s[d] = '0; m_p[d] = '0; m_c[d] = 0; m_v[d] = 1'b0; m_r[d] = 0;
    end
  endfunction

  function automatic void model_step(int d, bit [9:0] a, bit ack);
    int served = (ack && m_v[d]) ? m_c[d] : -1;
    int win = -1;
    int best = 99;
    bit [9:0] ev;
    bit [9:0] np;
    for (int i = 0; i < 10; i++) begin
      if (m_p[d][i] && i != served) begin
        int key = MODE_OF[d] ? (i - m_r[d] + 10) % 10 : i;
        if (key < best) begin
          best = key;
          win = i;
        end
      end
    end
    ev = EDGE_OF[d] ? (a & ~m_s[d]) : a;
    for (int i = 0; i < 10; i++) np[i] = ev[i] | (m_p[d][i] & (i != served));
    if (!m_v[d] || ack) begin
      if (win >= 0) begin
        m_c[d] = win;
        m_v[d] = 1'b1;
      end else begin
        m_v[d] = 1'b0;
      end
    end
    if (served >= 0) m_r[d] = (served + 1) % 10;
    m_s[d] = a;
    m_p[d] = np;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, bus0.a, bus0.ack);
      model_step(1, bus1.a, bus1.ack);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus0.a = '0; bus0.ack = 1'b0;
    bus1.a = '0; bus1.ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus0.a = '0; bus1.a = '0;
    bus0.ack = 1'b1; bus1.ack = 1'b1;
    repeat (12) tick();
    bus0.ack = 1'b0; bus1.ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.a = 10'h3FF; bus0.ack = 1'b0;
    bus1.a = 10'h3FF; bus1.ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus0.any, bus0.vld, bus0.q} !== 6'd0) begin
      n_err++; $display("FAIL reset_hold0 any/vld/q=%b exp=000000", {bus0.any, bus0.vld, bus0.q});
    end
    n_cmp++;
    if ({bus1.any, bus1.vld, bus1.q} !== 6'd0) begin
      n_err++; $display("FAIL reset_hold1 any/vld/q=%b exp=000000", {bus1.any, bus1.vld, bus1.q});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus0.any, bus0.vld} !== 2'b10) begin
      n_err++; $display("FAIL reset_edge1 any/vld=%b exp=10", {bus0.any, bus0.vld});
    end
    tick();
    n_cmp++;
    if ({bus0.vld, bus0.q} !== 5'b1_0000) begin
      n_err++; $display("FAIL reset_edge2 vld/q=%b exp=10000", {bus0.vld, bus0.q});
    end
    n_cmp++;
    if ({bus1.vld, bus1.q} !== 5'b1_0000) begin
      n_err++; $display("FAIL reset_edge2_lvl vld/q=%b exp=10000", {bus1.vld, bus1.q});
    end
    $display("reset: released with all lines high, first code %0d", bus0.q);
    drain();
  endtask

  task automatic test_fixed();
    apply_reset();
    bus0.a = 10'h084;
    tick();
    bus0.a = '0;
    tick();
    n_cmp++;
    if ({bus0.vld, bus0.q} !== {1'b1, 4'd2}) begin
      n_err++; $display("FAIL fixed_first vld/q=%b/%0d exp=1/2", bus0.vld, bus0.q);
    end
    bus0.ack = 1'b1;
    tick();
    n_cmp++;
    if ({bus0.vld, bus0.q} !== {1'b1, 4'd7}) begin
      n_err++; $display("FAIL fixed_second vld/q=%b/%0d exp=1/7", bus0.vld, bus0.q);
    end
    tick();
    n_cmp++;
    if ({bus0.any, bus0.vld} !== 2'b00) begin
      n_err++; $display("FAIL fixed_empty any/vld=%b exp=00", {bus0.any, bus0.vld});
    end
    bus0.ack = 1'b0;
    $display("fixed: A2+A7 served as 2 then 7");
  endtask

  task automatic test_rr();
    int exp_seq [6] = '{0, 3, 9, 0, 3, 9};
    apply_reset();
    bus1.a = 10'h209;
    tick();
    tick();
    bus1.ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({bus1.vld, bus1.q} !== {1'b1, 4'(exp_seq[i])}) begin
        n_err++; $display("FAIL rr_seq[%0d] vld/q=%b/%0d exp=1/%0d", i, bus1.vld, bus1.q, exp_seq[i]);
      end
      $display("rr: grant %0d code %0d", i, bus1.q);
      tick();
    end
    drain();
  endtask

  task automatic test_hold();
    apply_reset();
    bus0.a = 10'h020;
    tick();
    bus0.a = 10'h002;
    tick();
    bus0.a = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus0.vld, bus0.q} !== {1'b1, 4'd5}) begin
        n_err++; $display("FAIL hold[%0d] vld/q=%b/%0d exp=1/5", i, bus0.vld, bus0.q);
      end
      tick();
    end
    bus0.ack = 1'b1;
    tick();
    bus0.ack = 1'b0;
    n_cmp++;
    if ({bus0.vld, bus0.q} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL hold_after_ack vld/q=%b/%0d exp=1/1", bus0.vld, bus0.q);
    end
    $display("hold: code 5 kept until ack, then code %0d", bus0.q);
    drain();
  endtask

  task automatic test_set_beats_clear();
    apply_reset();
    bus0.a = 10'h010;
    tick();
    bus0.a = '0;
    tick();
    n_cmp++;
    if ({bus0.vld, bus0.q} !== {1'b1, 4'd4}) begin
      n_err++; $display("FAIL sbc_first vld/q=%b/%0d exp=1/4", bus0.vld, bus0.q);
    end
    bus0.a = 10'h010;
    bus0.ack = 1'b1;
    tick();
    bus0.ack = 1'b0;
    n_cmp++;
    if ({bus0.any, bus0.vld} !== 2'b10) begin
      n_err++; $display("FAIL sbc_pending any/vld=%b exp=10", {bus0.any, bus0.vld});
    end
    tick();
    n_cmp++;
    if ({bus0.vld, bus0.q} !== {1'b1, 4'd4}) begin
      n_err++; $display("FAIL sbc_again vld/q=%b/%0d exp=1/4", bus0.vld, bus0.q);
    end
    $display("set_beats_clear: channel 4 re-presented");
    drain();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus0.a = 10'h1C0;
    tick();
    bus0.a = '0;
    tick();
    n_cmp++;
    if ({bus0.any, bus0.vld, bus0.q} !== {2'b11, 4'd6}) begin
      n_err++; $display("FAIL areset_pre any/vld/q=%b exp=110110", {bus0.any, bus0.vld, bus0.q});
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus0.any, bus0.vld, bus0.q} !== 6'd0) begin
      n_err++; $display("FAIL areset_now any/vld/q=%b exp=000000", {bus0.any, bus0.vld, bus0.q});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus0.any, bus0.vld} !== 2'b00) begin
      n_err++; $display("FAIL areset_after any/vld=%b exp=00", {bus0.any, bus0.vld});
    end
    $display("async_reset: pending 6,7,8 discarded");
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bus0.a = 10'($urandom & $urandom);
      bus1.a = 10'($urandom & $urandom & $urandom);
      bus0.ack = ($urandom_range(0, 2) != 0);
      bus1.ack = ($urandom_range(0, 2) != 0);
      tick();
      n_cmp++;
      if ({bus0.any, bus0.vld, bus0.q} !== {|m_p[0], m_v[0], 4'(m_c[0])}) begin
        n_err++;
        $display("FAIL rand0[%0d] any/vld/q=%b/%b/%0d exp=%b/%b/%0d", n,
                 bus0.any, bus0.vld, bus0.q, |m_p[0], m_v[0], m_c[0]);
      end
      n_cmp++;
      if ({bus1.any, bus1.vld, bus1.q} !== {|m_p[1], m_v[1], 4'(m_c[1])}) begin
        n_err++;
        $display("FAIL rand1[%0d] any/vld/q=%b/%b/%0d exp=%b/%b/%0d", n,
                 bus1.any, bus1.vld, bus1.q, |m_p[1], m_v[1], m_c[1]);
      end
    end
    $display("random: 400 cycles on both instances");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fixed();
    test_rr();
    test_hold();
    test_set_beats_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
